// File: rtl/inv_sub_bytes_engine.sv
// AES InvSubBytes over one 128-bit state, LANES bytes per cycle, with every
// result byte re-encrypted through the forward S-box and compared to its input.
module inv_sub_bytes_engine #(
   parameter int unsigned LANES = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic         out_error,
   output logic [15:0]  err_mask,
   input  logic         fault_inj
);

   localparam int unsigned NBYTES = 16;
   localparam int unsigned IDX_W  = 4;

   // byte k of the state lives in element [15-k]
   typedef logic [NBYTES-1:0][7:0] blk_t;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // GF(2^8) arithmetic modulo x^8+x^4+x^3+x+1; the S-boxes are derived
   // from it so forward and inverse tables are exact inverses by construction.
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // a^254 == a^-1 for a != 0, and maps 0 to 0 as the S-box needs
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      r = a;
      for (int i = 0; i < 6; i++) r = gmul(gmul(r, r), a);
      return gmul(r, r);
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] v, input int unsigned n);
      return (v << n) | (v >> (8 - n));
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] q;
      q = gf_inv(a);
      return q ^ rotl(q, 1) ^ rotl(q, 2) ^ rotl(q, 3) ^ rotl(q, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] s);
      return gf_inv(rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05);
   endfunction

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   blk_t               in_q, in_d;
   blk_t               out_q, out_d;
   logic [NBYTES-1:0]  err_q, err_d;
   logic               valid_q, valid_d;

   // next-state and lane datapath
   always_comb begin
      logic [IDX_W-1:0] k;
      logic [7:0]       x;
      logic [7:0]       y;
      state_d = state_q;
      idx_d   = idx_q;
      in_d    = in_q;
      out_d   = out_q;
      err_d   = err_q;
      valid_d = valid_q;
      k       = '0;
      x       = '0;
      y       = '0;
      unique case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               in_d    = in_state;
               idx_d   = '0;
               err_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            for (int j = 0; j < int'(LANES); j++) begin
               k = idx_q + IDX_W'(j);
               x = in_q[IDX_W'(NBYTES - 1) - k];
               y = inv_sbox(x) ^ {7'b0, (j == 0) && fault_inj};
               out_d[IDX_W'(NBYTES - 1) - k] = y;
               err_d[IDX_W'(NBYTES - 1) - k] = (sbox(y) != x);
            end
            idx_d = idx_q + IDX_W'(LANES);
            if (idx_q == IDX_W'(NBYTES - LANES)) begin
               state_d = DONE;
               valid_d = 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
               valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         in_q    <= '0;
         out_q   <= '0;
         err_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         in_q    <= in_d;
         out_q   <= out_d;
         err_q   <= err_d;
         valid_q <= valid_d;
      end
   end

   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = valid_q;
   assign out_state = out_q;
   assign err_mask  = err_q;
   assign out_error = |err_q;

endmodule
